// File: rtl/clksel_ctrl_if.sv
// CPU bus and clock-controller handshake bundle for clksel_ctrl.
// The controller uses the slave view; the CPU/clock-controller side uses the master view.
interface clksel_ctrl_if;
  logic        vda;
  logic        vpa;
  logic [23:0] addr;
  logic        fast_en;
  logic        clr_timeout;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        hsclk_sel;
  logic        rdy;
  logic        sw_busy;
  logic        sw_timeout;

  modport master (
    output vda, vpa, addr, fast_en, clr_timeout, hsclk_selected, lsclk_selected,
    input  hsclk_sel, rdy, sw_busy, sw_timeout
  );

  modport slave (
    input  vda, vpa, addr, fast_en, clr_timeout, hsclk_selected, lsclk_selected,
    output hsclk_sel, rdy, sw_busy, sw_timeout
  );
endinterface

// File: rtl/clksel_ctrl.sv
// CPU clock-speed selector: requests LS/HS clock per access region, stalls the CPU
// via rdy until the clock controller confirms the switch, and flags acknowledge timeouts.
module clksel_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          lsclk_in,
  input  logic          rst_b,
  clksel_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {LS, TO_HS, HS, TO_LS} state_t;

  localparam logic [3:0] DWELL_MIN = 4'(DWELL_CYCLES);
  localparam logic [3:0] TO_LIMIT  = 4'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [3:0]             dwell_cnt;
  logic [3:0]             to_cnt;
  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hsclk_sel_q;
  logic                   rdy_q;
  logic                   sw_busy_q;
  logic                   sw_timeout_q;

  logic access;
  logic io_region;
  logic want_hs;
  logic force_ls;
  logic hs_ack;
  logic ls_ack;
  logic hs_ok;
  logic ls_ok;
  logic timeout_hit;

  // NOTE: ls chain resets to all-1 so an idle controller already reads as "LS confirmed".
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.lsclk_selected};
    end
  end

  assign hs_ack = hs_sync[SYNC_STAGES-1];
  assign ls_ack = ls_sync[SYNC_STAGES-1];
  assign hs_ok  = hs_ack & ~ls_ack;
  assign ls_ok  = ls_ack & ~hs_ack;

  // Bank 0 pages 0xFC..0xFE hold slow I/O; bank 0 upper half is also kept at low speed.
  assign access    = bus.vda | bus.vpa;
  assign io_region = (bus.addr[23:16] == 8'h00) &&
                     (bus.addr[15:8] >= 8'hFC) && (bus.addr[15:8] <= 8'hFE);
  assign want_hs   = bus.fast_en & access & ~io_region &
                     ((bus.addr[23:16] != 8'h00) | ~bus.addr[15]);
  assign force_ls  = ~bus.fast_en | (access & io_region);

  // An abort or a valid acknowledge in the same cycle pre-empts the timeout.
  assign timeout_hit = (to_cnt == TO_LIMIT) &&
                       (((state == TO_HS) && !force_ls && !hs_ok) ||
                        ((state == TO_LS) && !ls_ok));

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees the pre-edge values regardless of statement order.
  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state        <= LS;
      hsclk_sel_q  <= 1'b0;
      rdy_q        <= 1'b1;
      sw_busy_q    <= 1'b0;
      sw_timeout_q <= 1'b0;
      dwell_cnt    <= '0;
      to_cnt       <= '0;
    end else begin
      case (state)
        LS: begin
          if (dwell_cnt != 4'hF) dwell_cnt <= dwell_cnt + 4'd1;
          if (want_hs && !force_ls && (dwell_cnt >= DWELL_MIN)) begin
            state       <= TO_HS;
            hsclk_sel_q <= 1'b1;
            rdy_q       <= 1'b0;
            sw_busy_q   <= 1'b1;
            to_cnt      <= '0;
          end
        end
        TO_HS: begin
          if (force_ls || timeout_hit) begin
            state       <= TO_LS;
            hsclk_sel_q <= 1'b0;
            rdy_q       <= 1'b0;
            sw_busy_q   <= 1'b1;
            to_cnt      <= '0;
          end else if (hs_ok) begin
            state       <= HS;
            hsclk_sel_q <= 1'b1;
            rdy_q       <= 1'b1;
            sw_busy_q   <= 1'b0;
          end else if (to_cnt != 4'hF) begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        HS: begin
          if (force_ls || (access && !want_hs)) begin
            state       <= TO_LS;
            hsclk_sel_q <= 1'b0;
            rdy_q       <= 1'b0;
            sw_busy_q   <= 1'b1;
            to_cnt      <= '0;
          end
        end
        TO_LS: begin
          // rdy stays low past a timeout: the CPU never runs on an unconfirmed clock.
          if (ls_ok) begin
            state       <= LS;
            hsclk_sel_q <= 1'b0;
            rdy_q       <= 1'b1;
            sw_busy_q   <= 1'b0;
            dwell_cnt   <= '0;
          end else if (to_cnt != 4'hF) begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        default: begin
          state       <= LS;
          hsclk_sel_q <= 1'b0;
          rdy_q       <= 1'b1;
          sw_busy_q   <= 1'b0;
          dwell_cnt   <= '0;
        end
      endcase

      if (timeout_hit)          sw_timeout_q <= 1'b1;
      else if (bus.clr_timeout) sw_timeout_q <= 1'b0;
    end
  end

  assign bus.hsclk_sel  = hsclk_sel_q;
  assign bus.rdy        = rdy_q;
  assign bus.sw_busy    = sw_busy_q;
  assign bus.sw_timeout = sw_timeout_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed bench for clksel_ctrl: speed switches, dwell gating, aborts, timeouts, reset.
module tb_clksel_ctrl;

  localparam int SYNC = 2;

  // {hsclk_sel, rdy, sw_busy, sw_timeout} per state, timeout bit clear
  localparam logic [3:0] O_LS   = 4'b0100;
  localparam logic [3:0] O_TOHS = 4'b1010;
  localparam logic [3:0] O_HS   = 4'b1100;
  localparam logic [3:0] O_TOLS = 4'b0010;
  localparam logic [3:0] T_BIT  = 4'b0001;

  logic lsclk_in;
  logic rst_b;
  int   n_vec = 0;
  int   n_bad = 0;

  clksel_ctrl_if bus ();

  clksel_ctrl #(.SYNC_STAGES(SYNC), .DWELL_CYCLES(4), .TIMEOUT_CYCLES(15)) dut (
    .lsclk_in (lsclk_in),
    .rst_b    (rst_b),
    .bus      (bus)
  );

  logic [3:0] outs;
  assign outs = {bus.hsclk_sel, bus.rdy, bus.sw_busy, bus.sw_timeout};

  initial begin
    lsclk_in = 1'b0;
    forever #5 lsclk_in = ~lsclk_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge lsclk_in);
    #1;
  endtask

  initial begin
    rst_b              = 1'b1;
    bus.vda            = 1'b0;
    bus.vpa            = 1'b0;
    bus.addr           = 24'h0;
    bus.fast_en        = 1'b0;
    bus.clr_timeout    = 1'b0;
    bus.hsclk_selected = 1'b0;
    bus.lsclk_selected = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    chk("reset_outs", outs, O_LS);
    chk("reset_to_cnt", dut.to_cnt, 0);
    chk("reset_dwell", dut.dwell_cnt, 0);
    tick(2);
    chk("reset_held", outs, O_LS);

    // Scenario 1: HS request gated until dwell reaches 4, then ack through synchroniser
    rst_b       = 1'b1;
    bus.fast_en = 1'b1;
    bus.vpa     = 1'b1;
    bus.addr    = 24'h010000;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("s1_dwell", outs, O_LS);
    end
    tick(1);
    chk("s1_to_hs", outs, O_TOHS);
    bus.hsclk_selected = 1'b1;
    bus.lsclk_selected = 1'b0;
    tick(2);
    chk("s1_sync_wait", outs, O_TOHS);
    tick(1);
    chk("s1_hs", outs, O_HS);

    // No access: hold current speed even with an I/O address on the bus
    bus.vpa  = 1'b0;
    bus.addr = 24'h00FE40;
    tick(2);
    chk("idle_hold_hs", outs, O_HS);

    // Scenario 2: I/O access forces LS
    bus.vda = 1'b1;
    tick(1);
    chk("s2_to_ls", outs, O_TOLS);
    bus.hsclk_selected = 1'b0;
    bus.lsclk_selected = 1'b1;
    tick(2);
    chk("s2_sync_wait", outs, O_TOLS);
    tick(1);
    chk("s2_ls", outs, O_LS);

    // Scenario 3: want_hs appears 2 cycles after LS entry
    tick(2);
    chk("s3_io_stay", outs, O_LS);
    bus.addr = 24'h007FFF;
    tick(1);
    chk("s3_dwell3", outs, O_LS);
    tick(1);
    chk("s3_dwell4", outs, O_LS);
    tick(1);
    chk("s3_to_hs", outs, O_TOHS);

    // Scenario 5: fast_en dropped during TO_HS aborts; rdy held until ls_ack
    bus.lsclk_selected = 1'b0;
    tick(1);
    chk("s5_no_ack_a", outs, O_TOHS);
    tick(1);
    chk("s5_no_ack_b", outs, O_TOHS);
    bus.fast_en = 1'b0;
    tick(1);
    chk("s5_abort", outs, O_TOLS);
    tick(2);
    chk("s5_hold_rdy", outs, O_TOLS);
    bus.lsclk_selected = 1'b1;
    tick(2);
    chk("s5_sync_wait", outs, O_TOLS);
    tick(1);
    chk("s5_ls", outs, O_LS);

    // Scenario 4: TO_HS with no acknowledge times out at to_cnt=15
    bus.fast_en = 1'b1;
    bus.vda     = 1'b0;
    bus.vpa     = 1'b1;
    bus.addr    = 24'h123456;
    tick(4);
    chk("s4_dwell", outs, O_LS);
    tick(1);
    chk("s4_to_hs", outs, O_TOHS);
    tick(15);
    chk("s4_cnt15", outs, O_TOHS);
    tick(1);
    chk("s4_timeout", outs, O_TOLS | T_BIT);
    bus.fast_en = 1'b0;
    tick(1);
    chk("s4_sticky", outs, O_LS | T_BIT);
    bus.clr_timeout = 1'b1;
    tick(1);
    chk("s4_clear", outs, O_LS);
    bus.clr_timeout = 1'b0;

    // Timeout set and clr_timeout in the same cycle: set wins
    bus.fast_en = 1'b1;
    tick(3);
    chk("sw_dwell", outs, O_LS);
    tick(1);
    chk("sw_to_hs", outs, O_TOHS);
    tick(15);
    chk("sw_cnt15", outs, O_TOHS);
    bus.clr_timeout = 1'b1;
    tick(1);
    chk("sw_set_wins", outs, O_TOLS | T_BIT);
    bus.clr_timeout = 1'b0;
    bus.fast_en     = 1'b0;
    tick(1);
    chk("sw_sticky", outs, O_LS | T_BIT);
    bus.clr_timeout = 1'b1;
    tick(1);
    chk("sw_clear", outs, O_LS);
    bus.clr_timeout = 1'b0;

    // Scenario 6: reach HS, leave via bank-0 upper half, reset mid TO_LS
    bus.fast_en = 1'b1;
    tick(3);
    chk("s6_dwell", outs, O_LS);
    tick(1);
    chk("s6_to_hs", outs, O_TOHS);
    bus.hsclk_selected = 1'b1;
    bus.lsclk_selected = 1'b0;
    tick(3);
    chk("s6_hs", outs, O_HS);
    bus.vpa  = 1'b0;
    bus.vda  = 1'b1;
    bus.addr = 24'h008000;
    tick(1);
    chk("s6_upper_to_ls", outs, O_TOLS);
    tick(3);
    chk("s6_wait_ack", outs, O_TOLS);
    #2 rst_b = 1'b0;
    #1;
    chk("s6_async_outs", outs, O_LS);
    chk("s6_async_to_cnt", dut.to_cnt, 0);
    chk("s6_async_dwell", dut.dwell_cnt, 0);
    chk("s6_async_hs_sync", dut.hs_sync, 0);
    chk("s6_async_ls_sync", dut.ls_sync, (1 << SYNC) - 1);
    tick(1);
    chk("s6_reset_held", outs, O_LS);
    rst_b = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clksel_ctrl.md
CLKSEL_CTRL -- requirements
Module: clksel_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2; number of lsclk_in flops synchronising each clock-switch acknowledge (legal range 2-4).
REQ-002 SHALL have parameter DWELL_CYCLES, default 4; minimum lsclk_in cycles spent in state LS before an LS->HS request is issued (1-15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15; maximum lsclk_in cycles allowed for a switch acknowledge (2-15).
REQ-004 SHALL have port lsclk_in, input, 1, slow CPU clock; all state in this block updates on its rising edge.
REQ-005 SHALL have port rst_b, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port vda, input, 1, CPU valid data address.
REQ-007 SHALL have port vpa, input, 1, CPU valid program address.
REQ-008 SHALL have port addr, input, 24, CPU bank:address.
REQ-009 SHALL have port fast_en, input, 1, software enable for high-speed operation.
REQ-010 SHALL have port clr_timeout, input, 1, synchronous clear of sw_timeout.
REQ-011 SHALL have port hsclk_selected, input, 1, clock-controller acknowledge that the HS clock drives the CPU (asynchronous to lsclk_in).
REQ-012 SHALL have port lsclk_selected, input, 1, clock-controller acknowledge that the LS clock drives the CPU (asynchronous to lsclk_in).
REQ-013 SHALL have port hsclk_sel, output, 1, registered request to the clock controller (1 = high-speed clock).
REQ-014 SHALL have port rdy, output, 1, registered CPU ready; 0 stalls the CPU during a switch.
REQ-015 SHALL have port sw_busy, output, 1, registered flag, 1 in states TO_HS and TO_LS.
REQ-016 SHALL have port sw_timeout, output, 1, sticky flag indicating an acknowledge timeout.

Function
REQ-017 SHALL define io_region = (addr[23:16]==0) and (addr[15:8] in 0xFC..0xFE).
REQ-018 SHALL define want_hs = fast_en & (vda|vpa) & !io_region & ((addr[23:16]!=0) | !addr[15]); want_hs SHALL be evaluated at the lsclk_in rising edge.
REQ-019 SHALL define force_ls = !fast_en | ((vda|vpa) & io_region); force_ls SHALL override dwell gating.
REQ-020 When vda=vpa=0 and fast_en=1, the block SHALL hold its current target speed.
REQ-021 SHALL pass hsclk_selected and lsclk_selected each through a SYNC_STAGES-deep flop chain, producing hs_ack and ls_ack.
REQ-022 SHALL implement the FSM states LS, TO_HS, HS, TO_LS, with outputs hsclk_sel=0/1/1/0 and rdy=1/0/1/0 respectively.
REQ-023 LS->TO_HS SHALL occur when want_hs=1, force_ls=0 and dwell_cnt>=DWELL_CYCLES; otherwise the FSM stays in LS.
REQ-024 TO_HS->HS SHALL occur when hs_ack=1 and ls_ack=0.
REQ-025 TO_HS->TO_LS (abort) SHALL occur when force_ls=1, and this abort SHALL take priority over the acknowledge.
REQ-026 HS->TO_LS SHALL occur when force_ls=1, or when (vda|vpa)=1 and want_hs=0.
REQ-027 TO_LS->LS SHALL occur when ls_ack=1 and hs_ack=0.
REQ-028 dwell_cnt (4 bit) SHALL clear on LS entry, increment each cycle in LS, and saturate at 15.
REQ-029 to_cnt (4 bit) SHALL clear on entry to TO_HS or TO_LS, increment each cycle while in either state, and saturate at 15.
REQ-030 In TO_HS with to_cnt==TIMEOUT_CYCLES and no acknowledge, the block SHALL set sw_timeout and go to TO_LS.
REQ-031 In TO_LS with to_cnt==TIMEOUT_CYCLES, the block SHALL set sw_timeout and remain in TO_LS with rdy=0 until the acknowledge arrives; rdy SHALL never be released on an unconfirmed clock.
REQ-032 sw_timeout SHALL clear only on reset or on clr_timeout=1; when a set and a clear occur in the same cycle, the set SHALL win.
REQ-033 Latency: a request sampled at edge N SHALL appear on hsclk_sel and rdy after edge N; rdy SHALL return to 1 one edge after the qualifying acknowledge sample.

Reset
REQ-034 On rst_b=0, the block SHALL asynchronously enter state LS with hsclk_sel=0, rdy=1, sw_busy=0, sw_timeout=0 and dwell_cnt=0.
REQ-035 On rst_b=0, to_cnt SHALL be 0.
REQ-036 On rst_b=0, the hs_ack synchroniser SHALL be all-0 and the ls_ack synchroniser SHALL be all-1.
REQ-037 Reset asserted mid-switch SHALL abandon the switch immediately, with no glitch on hsclk_sel beyond the reset edge.

Verification
REQ-038 Scenario 1: fast_en=1, vpa=1, addr=0x010000 after 4 LS cycles -> hsclk_sel=1 and rdy=0; hsclk_selected=1 and lsclk_selected=0 -> rdy=1 SYNC_STAGES+1 edges later.
REQ-039 Scenario 2: in HS, vda=1, addr=0x00FE40 -> hsclk_sel=0 and rdy=0 next edge; state LS with rdy=1 after the acknowledge.
REQ-040 Scenario 3: want_hs=1 two cycles after LS entry -> the FSM stays in LS until dwell_cnt=4.
REQ-041 Scenario 4: TO_HS with no acknowledge -> sw_timeout=1 at to_cnt=15 and FSM in TO_LS; clr_timeout=1 -> sw_timeout=0.
REQ-042 Scenario 5: fast_en dropped during TO_HS -> same-edge abort to TO_LS, with rdy held at 0 until ls_ack=1.
REQ-043 Scenario 6: rst_b pulsed low during TO_LS -> all reset values of REQ-034 to REQ-036 appear immediately, with no clock edge required.
